nn_axil_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that turns simple command/response transfers into AXI4-Lite reads and writes.
- Host sequencers, the bring-up controller and the self-checking bench use it to program and poll the accelerator's register slave: CONTROL 0x00, STATUS 0x04, INPUT_ADDR 0x08, CONFIG 0x0C.
- One command in flight at a time; responses return in order.

---
 rtl/nn_axil_master.sv | 176 +++++++++++++++++
 tb/tb_nn_axil_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_axil_master.sv
// nn_axil_master: single-outstanding AXI4-Lite initiator behind a command/response port.
// Define NN_AXIL_POLL_EN to enable masked-compare poll reads (POLL_MAX / POLL_GAP).
module nn_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic                              cmd_poll,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_mask,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_match,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_err,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, POLL_GAP_ST, RSP} state_t;
    state_t r_state, w_next;
    logic r_aw_done, r_w_done, r_timeout;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic [DW/8-1:0] r_wstrb;
    logic [1:0] r_resp;
    logic w_accept, w_aw_hs, w_w_hs, w_r_done;
    logic w_poll_again, w_poll_timeout, w_skip_gap, w_gap_done;

    assign cmd_ready     = r_state == IDLE;
    assign busy          = r_state != IDLE;
    assign rsp_valid     = r_state == RSP;
    assign M_AXI_AWVALID = r_state == WR_REQ && !r_aw_done;
    assign M_AXI_WVALID  = r_state == WR_REQ && !r_w_done;
    assign M_AXI_BREADY  = r_state == WR_RESP;
    assign M_AXI_ARVALID = r_state == RD_REQ;
    assign M_AXI_RREADY  = r_state == RD_RESP;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_err       = r_resp[1];
    assign rsp_timeout   = r_timeout;
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign w_r_done      = M_AXI_RREADY && M_AXI_RVALID;

`ifdef NN_AXIL_POLL_EN
    localparam logic [15:0] LP_POLL_MAX = 16'(POLL_MAX);
    localparam logic [7:0]  LP_GAP      = 8'(POLL_GAP);
    logic r_poll;
    logic [DW-1:0] r_mask, r_match;
    logic [15:0] r_rd_cnt;
    logic [7:0] r_gap_cnt;
    logic w_miss, w_last;
    // An error response ends the poll immediately, so it never counts as a miss.
    assign w_miss         = r_poll && !M_AXI_RRESP[1] && ((M_AXI_RDATA & r_mask) != r_match);
    assign w_last         = r_rd_cnt == LP_POLL_MAX - 16'd1;
    assign w_poll_again   = w_miss && !w_last;
    assign w_poll_timeout = w_miss && w_last;
    assign w_skip_gap     = LP_GAP == 8'd0;
    assign w_gap_done     = r_gap_cnt == LP_GAP - 8'd1;
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_poll    <= 1'b0;
            r_mask    <= '0;
            r_match   <= '0;
            r_rd_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_poll    <= cmd_poll && !cmd_write;
                r_mask    <= cmd_mask;
                r_match   <= cmd_match;
                r_rd_cnt  <= '0;
                r_gap_cnt <= '0;
            end
            if (w_r_done) begin
                r_rd_cnt  <= r_rd_cnt + 16'd1;
                r_gap_cnt <= '0;
            end
            if (r_state == POLL_GAP_ST) r_gap_cnt <= r_gap_cnt + 8'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused       = ^{cmd_poll, cmd_mask, cmd_match, 16'(POLL_MAX), 8'(POLL_GAP)};
    assign w_poll_again   = 1'b0;
    assign w_poll_timeout = 1'b0;
    assign w_skip_gap     = 1'b1;
    assign w_gap_done     = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (cmd_valid) w_next = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:      if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
            WR_RESP:     if (M_AXI_BVALID) w_next = RSP;
            RD_REQ:      if (M_AXI_ARREADY) w_next = RD_RESP;
            RD_RESP:     if (M_AXI_RVALID) w_next = w_poll_again ? (w_skip_gap ? RD_REQ : POLL_GAP_ST) : RSP;
            POLL_GAP_ST: if (w_gap_done) w_next = RD_REQ;
            RSP:         if (rsp_ready) w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs) r_w_done <= 1'b1;
            if (M_AXI_BREADY && M_AXI_BVALID) begin
                r_rdata   <= '0;
                r_resp    <= M_AXI_BRESP;
                r_timeout <= 1'b0;
            end
            if (w_r_done) begin
                r_rdata   <= M_AXI_RDATA;
                r_resp    <= M_AXI_RRESP;
                r_timeout <= w_poll_timeout;
            end
        end
    end
endmodule

// File: tb/tb_nn_axil_master.sv
// tb_nn_axil_master: directed bench with a delay-programmable AXI4-Lite slave and a response scoreboard.
module tb_nn_axil_master;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic cmd_valid = 0, cmd_ready, cmd_write = 0, cmd_poll = 0;
    logic [7:0] cmd_addr = 0;
    logic [31:0] cmd_wdata = 0, cmd_mask = 0, cmd_match = 0;
    logic [3:0] cmd_wstrb = 0;
    logic rsp_valid, rsp_ready = 1, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [7:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    nn_axil_master #(.C_M_AXI_ADDR_WIDTH(8), .C_M_AXI_DATA_WIDTH(32), .POLL_MAX(4), .POLL_GAP(2)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_poll(cmd_poll),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .cmd_match(cmd_match), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct packed {logic [31:0] d; logic [1:0] r; logic t;} rsp_t;
    rsp_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r, input logic t);
        sb.push_back({d, r, t});
    endtask

    // Slave: readies/valids change at posedge+1, handshakes are judged at the preceding negedge.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [1:0] cfg_bresp = 0, cfg_rresp = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, aw_cyc = 0, w_cyc = 0;
    int ar_q[$];
    logic [31:0] rq[$];
    logic [7:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [3:0] last_wstrb;
    logic aw_f, w_f, b_f, ar_f, r_f, aw_seen, w_seen, ar_pend;
    initial begin
        {awready, wready, bvalid, arready, rvalid, aw_seen, w_seen, ar_pend} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f = wvalid && wready;
            b_f = bvalid && bready;
            ar_f = arvalid && arready;
            r_f = rvalid && rready;
            if (aw_f) last_awaddr = awaddr;
            if (w_f) begin last_wdata = wdata; last_wstrb = wstrb; end
            if (ar_f) last_araddr = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                {awready, wready, bvalid, arready, rvalid, aw_seen, w_seen, ar_pend} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
            end else begin
                if (aw_f) begin awready = 0; aw_cnt = 0; n_aw++; aw_seen = 1; aw_cyc = cyc; end
                else if (awvalid) begin if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++; end
                else aw_cnt = 0;
                if (w_f) begin wready = 0; w_cnt = 0; n_w++; w_seen = 1; w_cyc = cyc; end
                else if (wvalid) begin if (w_cnt >= w_dly) wready = 1; else w_cnt++; end
                else w_cnt = 0;
                if (ar_f) begin arready = 0; ar_cnt = 0; n_ar++; ar_pend = 1; ar_q.push_back(cyc); end
                else if (arvalid) begin if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++; end
                else ar_cnt = 0;
                if (b_f) begin bvalid = 0; n_b++; end
                else if (aw_seen && w_seen && !bvalid) begin
                    if (b_cnt >= b_dly) begin bvalid = 1; bresp = cfg_bresp; aw_seen = 0; w_seen = 0; b_cnt = 0; end
                    else b_cnt++;
                end
                if (r_f) rvalid = 0;
                else if (ar_pend && !rvalid) begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1; rresp = cfg_rresp; ar_pend = 0; r_cnt = 0;
                        if (rq.size() != 0) rdata = rq.pop_front();
                        else rdata = 32'hDEAD_BEEF;
                    end else r_cnt++;
                end
            end
        end
    end

    // Response monitor: compares at the negedge preceding each rsp handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.d);
                    chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.r});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.r[1]});
                    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.t});
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic poll, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] msk, input logic [31:0] mt);
        int n = 0;
        cmd_write = wr; cmd_poll = poll; cmd_addr = addr; cmd_wdata = wd;
        cmd_wstrb = st; cmd_mask = msk; cmd_match = mt; cmd_valid = 1;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("rsp_drain", sb.size(), 32'd0);
    endtask

    int na, nw, nb, lat, n;
    initial begin
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Write with AWREADY delayed: W completes first, AW three cycles later.
        aw_dly = 3; na = n_aw; nb = n_b;
        expect_rsp(32'd0, 2'b00, 1'b0);
        issue(1, 0, 8'h08, 32'h1000_0000, 4'hF, 0, 0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        wait_rsp();
        chk("wr_busy_after", {31'd0, busy}, 32'd0);
        chk("wr_aw_minus_w", aw_cyc - w_cyc, 32'd3);
        chk("wr_awaddr", {24'd0, last_awaddr}, 32'h08);
        chk("wr_wdata", last_wdata, 32'h1000_0000);
        chk("wr_wstrb", {28'd0, last_wstrb}, 32'hF);
        chk("wr_one_aw", n_aw - na, 32'd1);
        chk("wr_one_b", n_b - nb, 32'd1);
        aw_dly = 0;

        // Read with a 2-cycle RVALID delay.
        r_dly = 2; rq.push_back(32'h8000_0005);
        expect_rsp(32'h8000_0005, 2'b00, 1'b0);
        issue(0, 0, 8'h04, 0, 0, 0, 0);
        wait_rsp();
        chk("rd_araddr", {24'd0, last_araddr}, 32'h04);
        r_dly = 0;

        // Zero-wait latency: accept cycle to rsp_valid cycle.
        rq.push_back(32'h0000_00A5);
        expect_rsp(32'h0000_00A5, 2'b00, 1'b0);
        issue(0, 0, 8'h00, 0, 0, 0, 0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("rd_latency", lat, 32'd3);
        wait_rsp();

        // Response back-pressure with a pending command.
        rsp_ready = 0; rq.push_back(32'h1234_5678);
        expect_rsp(32'h1234_5678, 2'b00, 1'b0);
        issue(0, 0, 8'h0C, 0, 0, 0, 0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cmd_write = 1; cmd_poll = 0; cmd_addr = 8'h00; cmd_wdata = 32'h1; cmd_wstrb = 4'hF; cmd_valid = 1;
        expect_rsp(32'd0, 2'b00, 1'b0);
        na = n_ar; nw = n_aw;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'h1234_5678);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("hs_no_aw", {31'd0, awvalid}, 32'd0);
        chk("hs_no_ar", n_ar - na, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        chk("next_accept_aw", {31'd0, awvalid}, 32'd1);
        wait_rsp();
        chk("next_one_aw", n_aw - nw, 32'd1);

        // Error responses.
        cfg_rresp = 2'b10; rq.push_back(32'h0000_0042);
        expect_rsp(32'h0000_0042, 2'b10, 1'b0);
        issue(0, 0, 8'h04, 0, 0, 0, 0);
        wait_rsp();
        cfg_rresp = 2'b00; cfg_bresp = 2'b11;
        expect_rsp(32'd0, 2'b11, 1'b0);
        issue(1, 0, 8'h00, 32'hFFFF_FFFF, 4'h3, 0, 0);
        wait_rsp();
        cfg_bresp = 2'b00;

`ifdef NN_AXIL_POLL_EN
        // Poll: match on the third read, 2-cycle gaps between reads.
        ar_q.delete(); na = n_ar;
        rq.push_back(32'h0); rq.push_back(32'hFF); rq.push_back(32'h105);
        expect_rsp(32'h105, 2'b00, 1'b0);
        issue(0, 1, 8'h04, 0, 0, 32'h100, 32'h100);
        wait_rsp();
        chk("poll_reads", n_ar - na, 32'd3);
        chk("poll_gap1", ar_q[1] - ar_q[0], 32'd4);
        chk("poll_gap2", ar_q[2] - ar_q[1], 32'd4);
        // Poll exhausted after POLL_MAX reads.
        na = n_ar;
        rq.push_back(32'h1); rq.push_back(32'h2); rq.push_back(32'h3); rq.push_back(32'h4);
        expect_rsp(32'h4, 2'b00, 1'b1);
        issue(0, 1, 8'h04, 0, 0, 32'h100, 32'h100);
        wait_rsp();
        chk("poll_to_reads", n_ar - na, 32'd4);
        // Poll aborted by an error response.
        na = n_ar; cfg_rresp = 2'b10; rq.push_back(32'h7);
        expect_rsp(32'h7, 2'b10, 1'b0);
        issue(0, 1, 8'h04, 0, 0, 32'h100, 32'h100);
        wait_rsp();
        chk("poll_err_reads", n_ar - na, 32'd1);
        cfg_rresp = 2'b00;
`else
        // Without polling support a poll command is a single read.
        na = n_ar; rq.push_back(32'h3);
        expect_rsp(32'h3, 2'b00, 1'b0);
        issue(0, 1, 8'h04, 0, 0, 32'h100, 32'h100);
        wait_rsp();
        chk("nopoll_reads", n_ar - na, 32'd1);
`endif

        // Reset in the middle of a write request.
        aw_dly = 10; w_dly = 10;
        issue(1, 0, 8'h0C, 32'h5555_AAAA, 4'hF, 0, 0);
        chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("arst_valids", {30'd0, awvalid, wvalid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1; aw_dly = 0; w_dly = 0;
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rq.push_back(32'hCAFE_0001);
        expect_rsp(32'hCAFE_0001, 2'b00, 1'b0);
        issue(0, 0, 8'h08, 0, 0, 0, 0);
        wait_rsp();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
